instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set output FIFO entries (power of two, 2..16).
REQ-002 Parameter BASE_ADDR, default 16'h0000, SHALL set the first instruction-memory byte address written.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  encode request present.
REQ-006 req_ready  out  1  encoder can accept; high iff FIFO not full.
REQ-007 req_opcode  in  5  WISC-SP13 opcode.
REQ-008 req_rs / req_rt / req_rd  in  3 each  register fields.
REQ-009 req_func  in  2  R-format function field.
REQ-010 req_imm  in  16  immediate/displacement, two's complement.
REQ-011 resp_valid  out  1  one-cycle pulse reporting the result of an accepted request.
REQ-012 resp_err  out  1  qualified by resp_valid; 1 = request rejected, nothing written.
REQ-013 wr_en  out  1  instruction-memory write request; high iff FIFO not empty.
REQ-014 wr_addr  out  16  byte address of current write.
REQ-015 wr_data  out  16  encoded instruction word (FIFO head).
REQ-016 wr_ready  in  1  memory accepts write this cycle.
REQ-017 fifo_count  out  5  current FIFO occupancy.

Function
REQ-018 Accept SHALL occur on a rising edge with req_valid & req_ready; inputs are ignored otherwise.
REQ-019 Word[15:11] SHALL equal req_opcode in every legal format.
REQ-020 Opcodes 00000 (HALT), 00001 (NOP): word[10:0] SHALL be 0.
REQ-021 J-format 00100 (J), 00110 (JAL): word[10:0] = req_imm[10:0]; legal range -1024..1023.
REQ-022 I1-format 01000,01001,10000,10001,10011: word[10:8]=rs, [7:5]=rd, [4:0]=imm; signed range -16..15.
REQ-023 I1-format 01010,01011: as REQ-022; unsigned range 0..31.
REQ-024 I1-format 10100..10111 (shift/rotate immediate): as REQ-022; unsigned range 0..15.
REQ-025 I2-format 00101,00111,01100..01111,11000: word[10:8]=rs, [7:0]=imm; signed range -128..127.
REQ-026 I2-format 10010 (SLBI): as REQ-025; unsigned range 0..255.
REQ-027 R-format 11001..11111: word[10:8]=rs, [7:5]=rt, [4:2]=rd, [1:0]=func; func SHALL be forced 00 for 11001 and 11100..11111.
REQ-028 Opcodes 00010, 00011 and any out-of-range immediate SHALL be rejected: resp_err=1, no FIFO push, no state change except resp.
REQ-029 resp_valid SHALL assert exactly one cycle after the accepting edge (latency 1); deasserted otherwise.
REQ-030 A legal accept SHALL push the word into the FIFO on the accepting edge; wr_en visible the following cycle at earliest.
REQ-031 Pop SHALL occur on a rising edge with wr_en & wr_ready; wr_addr then SHALL increment by 2, wrapping 16'hFFFE -> 16'h0000.
REQ-032 wr_data/wr_addr SHALL hold stable while wr_en & !wr_ready.
REQ-033 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-034 When full, req_ready SHALL be 0 even if a pop occurs that cycle (no bypass).
REQ-035 FIFO SHALL be strictly in order; no entry lost or duplicated.

Reset
REQ-036 With rst_n=0 at an edge: fifo_count=0, wr_en=0, resp_valid=0, resp_err=0, wr_addr=BASE_ADDR, req_ready=1 the next cycle; pending entries discarded.
REQ-037 Request or write handshakes coincident with reset SHALL have no effect.
REQ-038 wr_data SHALL be 16'h0000 after reset until the first push.

Verification
REQ-039 ADD: opcode 11011, rs=1, rt=2, rd=3, func=00, wr_ready=1 -> resp_valid, resp_err=0; write wr_addr 0x0000, wr_data 0xD94C.
REQ-040 ADDI opcode 01000, rs=1, rd=2, imm=-1 -> wr_data 0x415F; same with imm=16 -> resp_err=1, no write, wr_addr unchanged.
REQ-041 J imm=-1024 -> wr_data 0x2400; J imm=1024 -> resp_err=1; opcode 00010 -> resp_err=1.
REQ-042 wr_ready=0, 4 legal back-to-back requests -> req_ready=0 after fourth, fifo_count=4; raise wr_ready -> 4 writes at 0x0000,0x0002,0x0004,0x0006 in order.
REQ-043 Continuous push and pop at occupancy 2 for 10 cycles -> fifo_count stays 2, data order preserved.
REQ-044 Reset asserted with fifo_count=2, wr_addr=0x0010 -> next cycle fifo_count=0, wr_en=0, wr_addr=BASE_ADDR, no further writes.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Encodes WISC-SP13 instruction fields into 16-bit words and queues them
//   in a small in-order FIFO that drains into instruction memory at
//   consecutive byte addresses starting at BASE_ADDR.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   encode request handshake (ready iff FIFO not full)
//   req_opcode/rs/rt/rd/func/imm  instruction fields
//   resp_valid/resp_err   one-cycle response per accepted request
//   wr_en/wr_addr/wr_data instruction-memory write (FIFO head)
//   wr_ready              memory accepts the write this cycle
//   fifo_count            current FIFO occupancy
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [2:0]  req_rs,
  input  logic [2:0]  req_rt,
  input  logic [2:0]  req_rd,
  input  logic [1:0]  req_func,
  input  logic [15:0] req_imm,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ready,
  output logic [4:0]  fifo_count
);

  localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL_COUNT = 5'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic [15:0]   r_addr;
  logic          r_resp_valid;
  logic          r_resp_err;

  logic [15:0]   w_word;
  logic          w_legal;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  // Instruction word assembly and immediate range legality per opcode.
  // A signed N-bit range check means imm[15:N-1] is all zeros or all ones.
  always_comb begin
    w_word  = 16'h0000;
    w_legal = 1'b0;
    case (req_opcode)
      5'b00000, 5'b00001: begin
        w_word  = {req_opcode, 11'h000};
        w_legal = 1'b1;
      end
      5'b00100, 5'b00110: begin
        w_word  = {req_opcode, req_imm[10:0]};
        w_legal = (req_imm[15:10] == 6'h00) || (req_imm[15:10] == 6'h3F);
      end
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
        w_word  = {req_opcode, req_rs, req_rd, req_imm[4:0]};
        w_legal = (req_imm[15:4] == 12'h000) || (req_imm[15:4] == 12'hFFF);
      end
      5'b01010, 5'b01011: begin
        w_word  = {req_opcode, req_rs, req_rd, req_imm[4:0]};
        w_legal = (req_imm[15:5] == 11'h000);
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        w_word  = {req_opcode, req_rs, req_rd, req_imm[4:0]};
        w_legal = (req_imm[15:4] == 12'h000);
      end
      5'b00101, 5'b00111, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000: begin
        w_word  = {req_opcode, req_rs, req_imm[7:0]};
        w_legal = (req_imm[15:7] == 9'h000) || (req_imm[15:7] == 9'h1FF);
      end
      5'b10010: begin
        w_word  = {req_opcode, req_rs, req_imm[7:0]};
        w_legal = (req_imm[15:8] == 8'h00);
      end
      5'b11010, 5'b11011: begin
        w_word  = {req_opcode, req_rs, req_rt, req_rd, req_func};
        w_legal = 1'b1;
      end
      // These R-format ops have no function variants, so func is forced 00.
      5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
        w_word  = {req_opcode, req_rs, req_rt, req_rd, 2'b00};
        w_legal = 1'b1;
      end
      default: begin
        w_word  = 16'h0000;
        w_legal = 1'b0;
      end
    endcase
  end

  // Readiness is taken from the registered count only, so a pop in the
  // same cycle never frees a slot for a request (no bypass when full).
  assign req_ready  = (r_count != FULL_COUNT);
  assign wr_en      = (r_count != 5'd0);
  assign w_accept   = req_valid & req_ready;
  assign w_push     = w_accept & w_legal;
  assign w_pop      = wr_en & wr_ready;

  assign wr_addr    = r_addr;
  assign wr_data    = r_mem[r_rptr];
  assign fifo_count = r_count;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;

  // FIFO storage, pointers, occupancy, write address and response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= 5'd0;
      r_addr       <= BASE_ADDR;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_err   <= w_accept & ~w_legal;
      if (w_push) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
        r_addr <= r_addr + 16'd2;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed plus short random stimulus for instr_encoder. A reference model
//   pushes expected words into a queue on each legal accept and a monitor
//   compares the DUT write port, occupancy and responses every cycle.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [15:0] BASE_ADDR = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [2:0]  req_rs;
  logic [2:0]  req_rt;
  logic [2:0]  req_rd;
  logic [1:0]  req_func;
  logic [15:0] req_imm;
  logic        resp_valid;
  logic        resp_err;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_q[$];
  int          m_count = 0;
  logic [15:0] m_addr  = BASE_ADDR;
  logic        m_rv    = 1'b0;
  logic        m_re    = 1'b0;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_func(req_func), .req_imm(req_imm),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: {legal, word}, ranges checked on the signed integer value.
  function automatic logic [16:0] enc(input logic [4:0] op, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [2:0] rd,
                                      input logic [1:0] fn, input logic [15:0] imm);
    int v;
    logic ok;
    logic [15:0] w;
    v  = int'($signed(imm));
    ok = 1'b0;
    w  = 16'h0000;
    case (op)
      5'd0, 5'd1:                          begin ok = 1'b1; w = {op, 11'd0}; end
      5'd4, 5'd6:                          begin ok = (v >= -1024 && v <= 1023); w = {op, imm[10:0]}; end
      5'd8, 5'd9, 5'd16, 5'd17, 5'd19:     begin ok = (v >= -16 && v <= 15); w = {op, rs, rd, imm[4:0]}; end
      5'd10, 5'd11:                        begin ok = (v >= 0 && v <= 31); w = {op, rs, rd, imm[4:0]}; end
      5'd20, 5'd21, 5'd22, 5'd23:          begin ok = (v >= 0 && v <= 15); w = {op, rs, rd, imm[4:0]}; end
      5'd5, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15, 5'd24:
                                           begin ok = (v >= -128 && v <= 127); w = {op, rs, imm[7:0]}; end
      5'd18:                               begin ok = (v >= 0 && v <= 255); w = {op, rs, imm[7:0]}; end
      5'd26, 5'd27:                        begin ok = 1'b1; w = {op, rs, rt, rd, fn}; end
      5'd25, 5'd28, 5'd29, 5'd30, 5'd31:   begin ok = 1'b1; w = {op, rs, rt, rd, 2'b00}; end
      default:                             begin ok = 1'b0; w = 16'h0000; end
    endcase
    return {ok, w};
  endfunction

  // Monitor: on each falling edge compare DUT against the model, then advance
  // the model with the inputs that the next rising edge will sample.
  initial begin
    logic [16:0] e;
    logic        acc;
    logic        pop;
    bit          first;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (!first) begin
        check16("fifo_count", {11'd0, fifo_count}, 16'(m_count));
        check1("req_ready", req_ready, m_count != DEPTH);
        check1("wr_en", wr_en, m_count != 0);
        check16("wr_addr", wr_addr, m_addr);
        if (m_count != 0) check16("wr_data", wr_data, m_q[0]);
        check1("resp_valid", resp_valid, m_rv);
        if (m_rv) check1("resp_err", resp_err, m_re);
      end
      first = 1'b0;
      if (!rst_n) begin
        m_q.delete();
        m_count = 0;
        m_addr  = BASE_ADDR;
        m_rv    = 1'b0;
        m_re    = 1'b0;
      end else begin
        acc  = req_valid && (m_count != DEPTH);
        pop  = (m_count != 0) && wr_ready;
        e    = enc(req_opcode, req_rs, req_rt, req_rd, req_func, req_imm);
        m_rv = acc;
        m_re = acc && !e[16];
        if (pop) begin
          void'(m_q.pop_front());
          m_addr = m_addr + 16'd2;
        end
        if (acc && e[16]) m_q.push_back(e[15:0]);
        m_count = m_q.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [4:0] op, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input logic [1:0] fn, input logic [15:0] imm);
    req_valid  = v;
    req_opcode = op;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_func   = fn;
    req_imm    = imm;
  endtask

  // Directed stimulus sequence.
  initial begin
    logic [15:0] r;
    int          sel;
    rst_n    = 1'b0;
    wr_ready = 1'b0;
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    tick();
    tick();
    check16("rst_count", {11'd0, fifo_count}, 16'h0000);
    check1("rst_wr_en", wr_en, 1'b0);
    check1("rst_ready", req_ready, 1'b1);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check16("rst_wr_data", wr_data, 16'h0000);
    check16("rst_wr_addr", wr_addr, BASE_ADDR);

    rst_n    = 1'b1;
    wr_ready = 1'b1;
    // ADD r3 = r1 + r2
    set_req(1'b1, 5'b11011, 3'd1, 3'd2, 3'd3, 2'b00, 16'h0000);
    tick();
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check1("add_resp_valid", resp_valid, 1'b1);
    check1("add_resp_err", resp_err, 1'b0);
    check1("add_wr_en", wr_en, 1'b1);
    check16("add_wr_addr", wr_addr, 16'h0000);
    check16("add_wr_data", wr_data, 16'hD94C);

    // ADDI imm=-1 (legal) then imm=16 (out of range)
    set_req(1'b1, 5'b01000, 3'd1, 3'd0, 3'd2, 2'b00, 16'hFFFF);
    tick();
    check16("addi_wr_data", wr_data, 16'h415F);
    check16("addi_wr_addr", wr_addr, 16'h0002);
    set_req(1'b1, 5'b01000, 3'd1, 3'd0, 3'd2, 2'b00, 16'd16);
    tick();
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check1("addi16_resp_err", resp_err, 1'b1);
    check1("addi16_wr_en", wr_en, 1'b0);
    check16("addi16_wr_addr", wr_addr, 16'h0004);

    // J boundary cases and reserved opcode
    set_req(1'b1, 5'b00100, 3'd0, 3'd0, 3'd0, 2'b00, 16'hFC00);
    tick();
    check16("j_min_wr_data", wr_data, 16'h2400);
    check1("j_min_resp_err", resp_err, 1'b0);
    set_req(1'b1, 5'b00100, 3'd0, 3'd0, 3'd0, 2'b00, 16'd1024);
    tick();
    check1("j_1024_resp_err", resp_err, 1'b1);
    set_req(1'b1, 5'b00010, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000);
    tick();
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check1("op2_resp_err", resp_err, 1'b1);
    tick();
    check1("idle_resp_valid", resp_valid, 1'b0);

    // Random traffic around every immediate range boundary
    for (int i = 0; i < 60; i++) begin
      r   = 16'($urandom);
      sel = int'($urandom_range(0, 3));
      set_req(1'($urandom_range(0, 1)), 5'($urandom), 3'($urandom), 3'($urandom),
              3'($urandom), 2'($urandom), 16'h0000);
      case (sel)
        0:       req_imm = r;
        1:       req_imm = {{11{r[5]}}, r[4:0]};
        2:       req_imm = {{7{r[9]}}, r[8:0]};
        default: req_imm = {{4{r[12]}}, r[11:0]};
      endcase
      wr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    wr_ready = 1'b1;
    repeat (6) tick();

    // Reset, then sustained push+pop at occupancy 2
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 5'b11010, 3'(i), 3'd5, 3'd6, 2'b10, 16'h0000);
      tick();
    end
    check16("pp_pre_count", {11'd0, fifo_count}, 16'h0002);
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 5'b11011, 3'(i), 3'(i + 1), 3'(i + 2), 2'(i), 16'h0000);
      tick();
      check16("pp_count", {11'd0, fifo_count}, 16'h0002);
    end
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    wr_ready = 1'b0;
    tick();
    check16("pp_post_addr", wr_addr, 16'h0014);

    // Reset with pending entries and coincident handshakes
    rst_n = 1'b0;
    wr_ready = 1'b1;
    set_req(1'b1, 5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    tick();
    rst_n = 1'b1;
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check16("rst2_count", {11'd0, fifo_count}, 16'h0000);
    check1("rst2_wr_en", wr_en, 1'b0);
    check16("rst2_wr_addr", wr_addr, BASE_ADDR);
    check1("rst2_resp_valid", resp_valid, 1'b0);
    tick();
    check1("rst2_no_write", wr_en, 1'b0);

    // Fill to full with memory stalled, then drain in order
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 5'b01001, 3'(i), 3'd0, 3'(7 - i), 2'd0, 16'(i));
      tick();
    end
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check1("full_ready", req_ready, 1'b0);
    check16("full_count", {11'd0, fifo_count}, 16'h0004);
    check16("full_wr_addr0", wr_addr, 16'h0000);
    check16("full_head", wr_data, 16'h4800 | 16'h00E0);
    // pop while full: the simultaneous request must not be taken
    wr_ready = 1'b1;
    set_req(1'b1, 5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    tick();
    set_req(1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check1("nobypass_resp", resp_valid, 1'b0);
    check16("nobypass_count", {11'd0, fifo_count}, 16'h0003);
    check16("drain_addr2", wr_addr, 16'h0002);
    tick();
    check16("drain_addr4", wr_addr, 16'h0004);
    tick();
    check16("drain_addr6", wr_addr, 16'h0006);
    tick();
    check1("drain_empty", wr_en, 1'b0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
